otter_writeback_stage: RTL and testbench

- Final stage of the multicycle OTTER datapath. Sits directly upstream of the register file write port.
- Accepts one completed instruction from execute/memory and selects the result source.
- For loads, waits for the L1 data-cache response, then aligns and sign- or zero-extends the returned word.
- Drives a registered, single-cycle write strobe, address and data into the register file.

---
 rtl/otter_writeback_stage.sv | 121 ++++++++++++
 tb/tb_otter_writeback_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_writeback_stage.sv
// OTTER writeback stage: selects the result source, waits on the data cache for loads,
// formats the returned word, and drives a registered single-cycle register-file write.
module otter_writeback_stage #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_csr,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy,
    output logic            ld_err
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, WRITE} state_t;

    // Timeout fires on the wait cycle whose increment would bring the counter to LOAD_TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t          state;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_lo;
    logic [7:0]      cnt;
    logic            accept;
    logic [XLEN-1:0] src;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic [XLEN-1:0] ld_data;
    logic            ld_ok;

    assign in_ready = (state != LOAD_WAIT);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (in_wb_sel)
            2'd0:    src = in_alu;
            2'd1:    src = in_pc4;
            default: src = in_csr;
        endcase
    end

    always_comb begin
        lb      = mem_rdata[{ld_lo, 3'b000} +: 8];
        lh      = ld_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ok   = 1'b1;
        ld_data = '0;
        case (ld_f3)
            3'b000:  ld_data = {{(XLEN-8){lb[7]}}, lb};
            3'b001:  ld_data = {{(XLEN-16){lh[15]}}, lh};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, lb};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, lh};
            default: ld_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            ld_err   <= 1'b0;
            ld_rd    <= '0;
            ld_f3    <= '0;
            ld_lo    <= '0;
            cnt      <= '0;
        end else begin
            rf_we  <= 1'b0;
            ld_err <= 1'b0;
            case (state)
                LOAD_WAIT: begin
                    // A response in the timeout cycle still wins.
                    if (mem_rvalid) begin
                        state    <= WRITE;
                        rf_we    <= (ld_rd != 5'd0);
                        rf_waddr <= ld_rd;
                        rf_wdata <= ld_data;
                        ld_err   <= !ld_ok;
                    end else if (cnt == TMO_LAST) begin
                        state  <= IDLE;
                        ld_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (in_wb_sel == 2'd3) begin
                            state <= LOAD_WAIT;
                            ld_rd <= in_rd;
                            ld_f3 <= in_funct3;
                            ld_lo <= in_addr_lo;
                            cnt   <= '0;
                        end else begin
                            state    <= WRITE;
                            rf_we    <= (in_rd != 5'd0);
                            rf_waddr <= in_rd;
                            rf_wdata <= src;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_otter_writeback_stage.sv
// Scoreboard bench for otter_writeback_stage: drivers push expected writes/errors with their
// cycle number, a negedge monitor pops and compares whenever the stage writes or flags an error.
module tb_otter_writeback_stage;
    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu = '0, in_pc4 = '0, in_csr = '0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        ld_err;

    otter_writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_pc4(in_pc4),
        .in_csr(in_csr), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .ld_err(ld_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatting straight from the RV32I load rules.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lo,
                                             input logic [31:0] w, output bit legal);
        int unsigned b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        legal = 1'b1;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd2: return w;
            3'd4: return b;
            3'd5: return h;
            default: begin legal = 1'b0; return 32'd0; end
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (rf_we || ld_err) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out actual we=%0d err=%0d waddr=%0d required none cyc=%0d",
                             rf_we, ld_err, rf_waddr, cyc);
                end else begin
                    e = q.pop_front();
                    check("out_cyc", cyc, e.cyc);
                    check("out_we", {31'd0, rf_we}, {31'd0, e.we});
                    check("out_err", {31'd0, ld_err}, {31'd0, e.err});
                    if (e.we) begin
                        check("out_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
                        check("out_wdata", rf_wdata, e.wdata);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++; failures++;
                $display("FAIL missing_out actual none required we=%0d err=%0d at cyc=%0d", e.we, e.err, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_nonload(input logic [4:0] rd, input logic [1:0] sel,
                              input logic [31:0] a, input logic [31:0] p, input logic [31:0] c);
        exp_t e;
        in_valid = 1'b1; in_rd = rd; in_wb_sel = sel;
        in_alu = a; in_pc4 = p; in_csr = c;
        in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
        check("ready_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        e.we = 1'b1; e.waddr = rd; e.err = 1'b0; e.cyc = cyc;
        e.wdata = (sel == 2'd0) ? a : (sel == 2'd1) ? p : c;
        if (rd != 0) q.push_back(e);
    endtask

    // Response is sampled d edges after the first wait edge; wait edges run out after TMO.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] w, input int d);
        exp_t e;
        bit legal;
        int acc;
        logic [31:0] fw;
        in_valid = 1'b1; in_rd = rd; in_wb_sel = 2'd3; in_funct3 = f3; in_addr_lo = lo;
        in_alu = $urandom; in_pc4 = $urandom; in_csr = $urandom;
        check("ready_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        acc = cyc;
        fw = ref_load(f3, int'(lo), w, legal);
        if (d + 1 <= TMO) begin
            e.we = (rd != 0); e.waddr = rd; e.wdata = fw; e.err = !legal; e.cyc = acc + 1 + d;
        end else begin
            e.we = 1'b0; e.waddr = rd; e.wdata = '0; e.err = 1'b1; e.cyc = acc + TMO;
        end
        if (e.we || e.err) q.push_back(e);
        for (int i = 0; i < d; i++) begin
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (i < TMO) begin
                // Offers made while waiting must be refused.
                in_valid = 1'($urandom); in_rd = 5'($urandom); in_wb_sel = 2'($urandom);
                in_alu = $urandom;
                check("ready_wait", {31'd0, in_ready}, 32'd0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = w;
        @(posedge clock); #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3s [5];
        logic [1:0]  los [5];
        logic [1:0]  sel;
        logic [4:0]  rd;
        f3s = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        los = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};

        #2 reset_n = 1'b0;
        #2;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_err", {31'd0, ld_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        do_nonload(5'd5, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
        idle(1);
        check("alu_then_idle", {31'd0, busy}, 32'd0);
        idle(1);

        do_nonload(5'd1, 2'd1, 32'h0, 32'h104, 32'h0);
        do_nonload(5'd2, 2'd2, 32'h0, 32'h0, 32'hDEAD);
        idle(2);

        for (int i = 0; i < 5; i++) begin
            do_load(5'(10 + i), f3s[i], los[i], 32'h80F1_7F82, 2);
        end
        idle(2);

        do_nonload(5'd0, 2'd0, 32'hFFFF_0000, 32'h0, 32'h0);
        check("rd0_busy", {31'd0, busy}, 32'd1);
        idle(1);
        check("rd0_idle", {31'd0, busy}, 32'd0);

        do_load(5'd7, 3'b011, 2'd0, 32'hFFFF_FFFF, 1);
        idle(2);

        do_load(5'd8, 3'b010, 2'd0, 32'h5555_AAAA, 5);
        check("tmo_idle", {31'd0, busy}, 32'd0);
        idle(2);

        do_nonload(5'd6, 2'd0, 32'hA5A5_0F0F, 32'h0, 32'h0);
        idle(2);
        in_valid = 1'b1; in_rd = 5'd9; in_wb_sel = 2'd3; in_funct3 = 3'd2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, rf_we}, 32'd0);
        check("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("mid_rst_wdata", rf_wdata, 32'd0);
        check("mid_rst_err", {31'd0, ld_err}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        check("stale_idle", {31'd0, busy}, 32'd0);
        idle(2);
        do_nonload(5'd3, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
        idle(2);

        for (int n = 0; n < 300; n++) begin
            sel = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (sel != 2'd3)
                do_nonload(rd, sel, $urandom, $urandom, $urandom);
            else
                do_load(rd, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
                        int'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(10);
        check("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
